// File: rtl/iir_pkg.sv
// ============================================================================
// Module      : iir_pkg
// Description : Shared constants and helpers for the IIR output buffer slice.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package iir_pkg;

    localparam int DW_DEFAULT = 12;
    localparam int CNT_W      = 16;

    // Ceiling log2, usable in constant expressions for pointer/level widths.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/iir_buf_ram.sv
// ============================================================================
// Module      : iir_buf_ram
// Description : DEPTH x DW register array, one synchronous write port and one
//               asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_buf_ram
    import iir_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 8,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/iir_out_buffer.sv
// ============================================================================
// Module      : iir_out_buffer
// Description : Elastic FIFO between the IIR filter and its consumer, with
//               sticky overflow flag. Optional IIR_BUF_STATS_EN adds
//               saturating accepted/dropped sample counters.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module iir_out_buffer
    import iir_pkg::*;
#(
    parameter int DW    = DW_DEFAULT,
    parameter int DEPTH = 8
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic [DW-1:0]            DIN,
    input  logic                     VIN,
    output logic [DW-1:0]            DOUT,
    output logic                     VOUT,
    input  logic                     READY,
    output logic                     FULL,
    output logic [clog2(DEPTH):0]    LEVEL,
    output logic                     OVF,
    output logic [CNT_W-1:0]         CNT_SAMPLES,
    output logic [CNT_W-1:0]         CNT_DROP
);

    localparam int AW = clog2(DEPTH);
    localparam int LW = AW + 1;
    localparam logic [LW-1:0] C_LEVEL_FULL = LW'(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q,  level_d;
    logic          ovf_q,    ovf_d;

    logic          w_empty;
    logic          w_full;
    logic          w_pop;
    logic          w_push;
    logic          w_drop;
    logic [DW-1:0] w_rdata;

    assign w_empty = (level_q == '0);
    assign w_full  = (level_q == C_LEVEL_FULL);

    // A pop frees a slot this cycle, so a full buffer can still take a push.
    assign w_pop  = !w_empty && READY;
    assign w_push = VIN && (!w_full || w_pop);
    assign w_drop = VIN && w_full && !w_pop;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        ovf_d    = ovf_q || w_drop;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({w_push, w_pop})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            ovf_q    <= ovf_d;
        end
    end

    iir_buf_ram #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk_i   (CLK),
        .we_i    (w_push && !RST),
        .waddr_i (wr_ptr_q),
        .wdata_i (DIN),
        .raddr_i (rd_ptr_q),
        .rdata_o (w_rdata)
    );

    assign VOUT  = !w_empty;
    assign DOUT  = w_empty ? '0 : w_rdata;
    assign FULL  = w_full;
    assign LEVEL = level_q;
    assign OVF   = ovf_q;

`ifdef IIR_BUF_STATS_EN
    logic [CNT_W-1:0] cnt_samples_q;
    logic [CNT_W-1:0] cnt_drop_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            cnt_samples_q <= '0;
            cnt_drop_q    <= '0;
        end else begin
            if (w_push && (cnt_samples_q != '1)) begin
                cnt_samples_q <= cnt_samples_q + 1'b1;
            end
            if (w_drop && (cnt_drop_q != '1)) begin
                cnt_drop_q <= cnt_drop_q + 1'b1;
            end
        end
    end

    assign CNT_SAMPLES = cnt_samples_q;
    assign CNT_DROP    = cnt_drop_q;
`else
    assign CNT_SAMPLES = '0;
    assign CNT_DROP    = '0;
`endif

endmodule

`default_nettype wire

// File: doc/iir_out_buffer.md
# iir_out_buffer

Elastic output buffer placed directly downstream of the IIR filter. It captures every filter result presented with the filter's output-valid strobe and stores it in a small FIFO. It then delivers the results to the consumer (output file writer or next processing stage) over a valid/ready handshake, so that consumer stalls never lose filter samples unless the buffer overflows. Overflow is flagged, never silently ignored.

## Interface
- DW, default 12: sample width; equals the filter output width.
- DEPTH, default 8: FIFO entries; power of two, ≥ 2.
- CLK  in  1  single clock; all state updates on the rising edge.
- RST  in  1  synchronous, active-high reset, sampled on the rising edge of CLK.
- DIN  in  DW  filter result; connects to the filter's DOUT.
- VIN  in  1  filter result valid; connects to the filter's VOUT.
- DOUT  out  DW  head-of-FIFO sample for the consumer.
- VOUT  out  1  DOUT valid (FIFO not empty).
- READY  in  1  consumer accepts DOUT this cycle.
- FULL  out  1  FIFO holds DEPTH entries.
- LEVEL  out  log2(DEPTH)+1  current occupancy.
- OVF  out  1  sticky: at least one sample was dropped since reset.
- CNT_SAMPLES  out  16  accepted-sample counter (only with IIR_BUF_STATS_EN).
- CNT_DROP  out  16  dropped-sample counter (only with IIR_BUF_STATS_EN).

## Operation
- Push: VIN=1 and (FULL=0 or pop in the same cycle) → write DIN at the write pointer and advance the pointer.
- Pop: VOUT=1 and READY=1 → advance the read pointer.
- Drop: VIN=1, FULL=1, no pop → sample discarded; OVF set to 1 and held until RST.
- Simultaneous push and pop:
  - When not empty: LEVEL unchanged.
  - When full: the push is accepted, not dropped.
  - When empty: the push only; VOUT=0 that cycle, so no pop is possible.
- READY while VOUT=0 has no effect.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. LEVEL is a separate counter that is incremented, decremented, or held.
- FULL = (LEVEL==DEPTH). VOUT = (LEVEL!=0).
- DOUT = mem[rd_ptr] when VOUT=1. DOUT is forced to 0 when empty.
- Data is passed through unmodified, with no width change.
- Reset values: pointers 0, LEVEL 0, VOUT 0, DOUT 0, FULL 0, OVF 0, counters 0. Memory contents are not reset.
- RST asserted mid-stream: all contents discarded at that edge. VIN and READY are ignored in the reset cycle.

## Timing
- Latency: a sample pushed at edge k is visible on DOUT with VOUT=1 from edge k onward, i.e. it is available for pop in cycle k+1 (one-cycle fall-through when empty).
- Throughput: one push and one pop per cycle sustained.
- FULL, LEVEL and OVF are registered and update on the same edge as the push, pop, or drop that causes them.
- The consumer must hold READY meaningful only in cycles where it wants data. Its back-pressure is never propagated to the filter; the filter has no stall input.

## Configuration
- IIR_BUF_STATS_EN defined:
  - CNT_SAMPLES increments on every accepted push.
  - CNT_DROP increments on every drop.
  - Both counters saturate at 16'hFFFF and clear on RST.
- Not defined: both ports are tied to 0 and no counter flops are built. FIFO behaviour is identical in both cases.

## Structure
- Shared package iir_pkg:
  - DW_DEFAULT=12.
  - Counter width CNT_W=16.
  - Function clog2 for pointer and LEVEL widths.
- Sub-module iir_buf_ram: DEPTH×DW register array with one synchronous write port and one asynchronous read port.
- The top level holds pointers, LEVEL, flags and stats.

## Test plan
- Reset then idle → VOUT=0, DOUT=0, LEVEL=0, FULL=0, OVF=0 for 10 cycles.
- READY=1 held, push 0x001..0x005 on consecutive cycles → DOUT sequence 0x001..0x005, each valid one cycle after its push; LEVEL never exceeds 1.
- READY=0, push 8 samples 0x100..0x107 → FULL=1, LEVEL=8. A 9th push 0x1FF → OVF=1, CNT_DROP=1. Then READY=1 → pops 0x100..0x107 in order and 0x1FF is never output.
- FULL with VIN=1 and READY=1 in the same cycle → push accepted, LEVEL stays 8, OVF stays 0.
- Fill to LEVEL=3, assert RST for one cycle with VIN=1 → LEVEL=0, VOUT=0, OVF=0, counters 0 after the edge; the sample presented during reset is not stored.
- Random VIN/READY over 10 000 cycles against a queue model → output order matches, drops counted exactly, CNT_SAMPLES equals accepted pushes (with IIR_BUF_STATS_EN).
